// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial sequence detector.
package seq_detect_pkg;

  localparam int unsigned MAX_LEN_DEF = 16;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned MASK_W      = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned len_w_f(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int unsigned LEN_W_DEF = len_w_f(MAX_LEN_DEF);

  // Low mask with 'len' ones; wide enough for any supported MAX_LEN.
  function automatic logic [MASK_W-1:0] mask_f(input logic [MASK_W-1:0] len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// Serial shift register with fill tracking and masked pattern compare.
module seq_shift_match
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_x,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_hit
);

  logic [MAX_LEN-1:0] r_shift;
  logic [LEN_W-1:0]   r_fill;
  logic [MASK_W-1:0]  w_diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_fill  <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_fill  <= '0;
    end else if (i_en) begin
      r_shift <= {r_shift[MAX_LEN-2:0], i_x};
      if (r_fill < i_len) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  always_comb begin
    w_diff              = '0;
    w_diff[MAX_LEN-1:0] = r_shift ^ i_pattern;
  end

  // A hit needs a full window of fresh bits, so stale history never matches.
  assign o_hit = (r_fill == i_len) && ((w_diff & mask_f(MASK_W'(i_len))) == '0);

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config handshake, run FSM and match counter around seq_shift_match.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter  int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter  int unsigned CNT_W   = CNT_W_DEF,
  localparam int unsigned LEN_W   = len_w_f(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic [CNT_W-1:0]   cfg_target_i,
  output logic               cfg_err_o,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               x_i,
  output logic               busy_o,
  output logic               detect_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               done_o
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_cfg_valid;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_ready;
  logic               r_cfg_err;

  logic               w_cfg_take;
  logic               w_len_ok;
  logic               w_start;
  logic               w_run;
  logic               w_hit;
  logic               w_detect;
  logic               w_tgt_hit;
  logic               w_run_entry;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_cfg_take = cfg_valid_i & r_cfg_ready;
  assign w_len_ok   = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(MAX_LEN));
  // A config offer always takes precedence over a start in the same cycle.
  assign w_start    = start_i & r_cfg_valid & ~cfg_valid_i;
  assign w_run      = (r_state == StRun);
  assign w_detect   = w_hit & w_run;
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_tgt_hit  = w_detect && (r_target != '0) && (w_cnt_inc == r_target);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (abort_i || (w_cfg_take && w_len_ok)) begin
          w_state_nxt = StIdle;
        end else if (w_start) begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (abort_i) begin
          w_state_nxt = StIdle;
        end else if (w_tgt_hit) begin
          w_state_nxt = StDone;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_run_entry = !w_run && (w_state_nxt == StRun);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cfg_valid <= 1'b0;
      r_pattern   <= '0;
      r_len       <= '0;
      r_target    <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt == StRun);
      r_done      <= (w_state_nxt == StDone);
      r_cfg_ready <= (w_state_nxt != StRun);
      r_cfg_err   <= w_cfg_take & ~w_len_ok;
      if (w_cfg_take && w_len_ok) begin
        r_pattern   <= cfg_pattern_i;
        r_len       <= cfg_len_i;
        r_target    <= cfg_target_i;
        r_cfg_valid <= 1'b1;
      end
      if (w_run_entry) begin
        r_cnt <= '0;
      end else if (w_detect) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  seq_shift_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_run_entry),
    .i_en      (w_run),
    .i_x       (x_i),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_hit     (w_hit)
  );

  assign cfg_ready_o = r_cfg_ready;
  assign cfg_err_o   = r_cfg_err;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign detect_o    = w_detect;
  assign match_cnt_o = r_cnt;

endmodule
